// File: rtl/gun_fire_controller.sv
// rtl/gun_fire_controller.sv - rate-limited bullet spawn requests with overheat lockout
// Define GUN_BURST_EN for edge-triggered bursts of BURST_LEN shots instead of level auto-fire.
module gun_fire_controller #(
  parameter logic [3:0]  HEAT_MAX    = 4'd15,
  parameter logic [3:0]  COOL_THRESH = 4'd4,
  parameter int unsigned FIRE_DIV    = 12_500_000,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned BURST_LEN   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       startGameEn,
  input  logic       shoot,
  input  logic [3:0] heat,
  input  logic       spawn_ack,
  output logic       spawn_req,
  output logic       spawn_drop,
  output logic       overheat,
  output logic [7:0] shots_fired,
  output logic [1:0] state_dbg
);

  localparam int RW = (FIRE_DIV > 1) ? $clog2(FIRE_DIV) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [RW-1:0] RELOAD_INIT = RW'(FIRE_DIV - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(ACK_TIMEOUT - 1);

  generate
    if (FIRE_DIV < 1 || ACK_TIMEOUT < 1 || BURST_LEN < 1) begin : g_bad_param
      $error("gun_fire_controller: FIRE_DIV, ACK_TIMEOUT and BURST_LEN must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    READY    = 2'd0,
    FIRE     = 2'd1,
    RELOAD   = 2'd2,
    OVERHEAT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rl_q, rl_d;
  logic [TW-1:0] to_q, to_d;
  logic          req_d, drop_d, ovh_d;
  logic [7:0]    shots_d;
  logic          fire_trig;
  logic          refire;

`ifdef GUN_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);
  logic          shoot_q;
  logic [BW-1:0] burst_q, burst_d;

  assign fire_trig = shoot & ~shoot_q;
  assign refire    = (burst_q != '0);

  always_ff @(posedge clock) begin
    if (!reset || startGameEn) begin
      shoot_q <= 1'b0;
      burst_q <= '0;
    end else begin
      shoot_q <= shoot;
      burst_q <= burst_d;
    end
  end
`else
  assign fire_trig = shoot;
  assign refire    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = spawn_req;
    drop_d  = 1'b0;
    ovh_d   = overheat;
    shots_d = shots_fired;
    rl_d    = rl_q;
    to_d    = to_q;
`ifdef GUN_BURST_EN
    burst_d = burst_q;
`endif
    case (state_q)
      READY: begin
        if (heat >= HEAT_MAX) begin
          state_d = OVERHEAT;
          ovh_d   = 1'b1;
        end else if (fire_trig) begin
          state_d = FIRE;
          req_d   = 1'b1;
          to_d    = '0;
`ifdef GUN_BURST_EN
          burst_d = BW'(BURST_LEN);
`endif
        end
      end
      FIRE: begin
        // An ack in the final timeout cycle still counts as a delivered shot.
        if (spawn_ack || to_q == TO_LAST) begin
          state_d = RELOAD;
          req_d   = 1'b0;
          rl_d    = RELOAD_INIT;
          if (spawn_ack) begin
            if (shots_fired != 8'hFF) shots_d = shots_fired + 8'd1;
          end else begin
            drop_d = 1'b1;
          end
`ifdef GUN_BURST_EN
          if (burst_q != '0) burst_d = burst_q - 1'b1;
`endif
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RELOAD: begin
        if (rl_q == '0) begin
          if (heat >= HEAT_MAX) begin
            state_d = OVERHEAT;
            ovh_d   = 1'b1;
`ifdef GUN_BURST_EN
            burst_d = '0;
`endif
          end else if (refire) begin
            state_d = FIRE;
            req_d   = 1'b1;
            to_d    = '0;
          end else begin
            state_d = READY;
          end
        end else begin
          rl_d = rl_q - 1'b1;
        end
      end
      OVERHEAT: begin
        // Release only well below the trip point so the lock does not chatter.
        if (heat <= COOL_THRESH) begin
          state_d = READY;
          ovh_d   = 1'b0;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset || startGameEn) begin
      state_q     <= READY;
      spawn_req   <= 1'b0;
      spawn_drop  <= 1'b0;
      overheat    <= 1'b0;
      shots_fired <= 8'd0;
      rl_q        <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      spawn_req   <= req_d;
      spawn_drop  <= drop_d;
      overheat    <= ovh_d;
      shots_fired <= shots_d;
      rl_q        <= rl_d;
      to_q        <= to_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_gun_fire_controller.sv
// tb/tb_gun_fire_controller.sv - randomized shot-level checks of gun_fire_controller
module tb_gun_fire_controller;

  localparam int         FIRE_DIV    = 4;
  localparam int         ACK_TIMEOUT = 8;
  localparam logic [3:0] HEAT_MAX    = 4'd15;
  localparam logic [3:0] COOL_THRESH = 4'd4;
`ifdef GUN_BURST_EN
  localparam int BURST = 3;
`else
  localparam int BURST = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       startGameEn = 1'b0;
  logic       shoot = 1'b0;
  logic [3:0] heat = 4'd0;
  logic       spawn_ack = 1'b0;
  logic       spawn_req;
  logic       spawn_drop;
  logic       overheat;
  logic [7:0] shots_fired;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int exp_shots = 0;

  gun_fire_controller #(
    .HEAT_MAX   (HEAT_MAX),
    .COOL_THRESH(COOL_THRESH),
    .FIRE_DIV   (FIRE_DIV),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .BURST_LEN  (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .startGameEn(startGameEn),
    .shoot      (shoot),
    .heat       (heat),
    .spawn_ack  (spawn_ack),
    .spawn_req  (spawn_req),
    .spawn_drop (spawn_drop),
    .overheat   (overheat),
    .shots_fired(shots_fired),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One shot from its first FIRE cycle; the ack arrives d cycles in (never if d >= ACK_TIMEOUT).
  task automatic shot(input int d, input logic [3:0] heat_reload, output logic [1:0] nxt);
    int k;
    int n;
    int exp_hi;
    k = 0;
    while (1) begin
      spawn_ack = (k == d);
      tick;
      spawn_ack = 1'b0;
      k++;
      if (!spawn_req || k > 40) break;
    end
    exp_hi = (d < ACK_TIMEOUT) ? d + 1 : ACK_TIMEOUT;
    chk("req_high_cycles", k, exp_hi);
    chk("drop_pulse", spawn_drop, (d >= ACK_TIMEOUT) ? 1 : 0);
    if (d < ACK_TIMEOUT && exp_shots < 255) exp_shots++;
    chk("shots_fired", shots_fired, exp_shots);
    heat = heat_reload;
    n = 0;
    while (state_dbg == 2'd2 && n < 20) begin
      n++;
      tick;
      if (n == 1) chk("drop_one_cycle", spawn_drop, 0);
    end
    chk("reload_cycles", n, FIRE_DIV);
    nxt = state_dbg;
  endtask

  // Trigger from READY; expects BURST shots unless the gun overheats at a reload end.
  task automatic trigger(input int dlo, input int dhi, input bit hot, input bit hold,
                         output logic [1:0] final_st);
    int rem;
    int d;
    bit first;
    logic [1:0] nxt;
    logic [3:0] hr;
    first = 1'b1;
    shoot = 1'b1;
    tick;
    chk("req_rise", spawn_req, 1);
    chk("fire_state", state_dbg, 1);
    if (!hold) shoot = 1'b0;
    rem = BURST;
    final_st = 2'd0;
    while (rem > 0) begin
      d  = $urandom_range(dlo, dhi);
      hr = (hot && first) ? HEAT_MAX : 4'($urandom_range(0, 14));
      first = 1'b0;
      shot(d, hr, nxt);
      rem--;
      if (hr >= HEAT_MAX) begin
        rem = 0;
        final_st = 2'd3;
      end else begin
        final_st = (rem > 0) ? 2'd1 : 2'd0;
      end
      chk("after_reload_state", nxt, final_st);
    end
    chk("overheat_flag", overheat, (final_st == 2'd3) ? 1 : 0);
  endtask

  task automatic cool;
    heat = 4'($urandom_range(5, 14));
    tick;
    chk("lock_hold_state", state_dbg, 3);
    chk("lock_hold_flag", overheat, 1);
    heat = 4'($urandom_range(0, 4));
    tick;
    chk("lock_release_state", state_dbg, 0);
    chk("lock_release_flag", overheat, 0);
  endtask

  task automatic idle;
    repeat ($urandom_range(1, 3)) begin
      spawn_ack = 1'($urandom_range(0, 1));
      tick;
      chk("idle_state", state_dbg, 0);
      chk("idle_shots", shots_fired, exp_shots);
    end
    spawn_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] f;
    int rises;
    int bad;
    int last;
    int cyc;
    logic prev;

    reset = 1'b0;
    tick;
    tick;
    chk("rst_state", state_dbg, 0);
    chk("rst_req", spawn_req, 0);
    chk("rst_drop", spawn_drop, 0);
    chk("rst_overheat", overheat, 0);
    chk("rst_shots", shots_fired, 0);
    reset = 1'b1;
    heat = 4'd2;
    tick;

    trigger(3, 3, 1'b0, 1'b0, f);
    idle;
    trigger(100, 100, 1'b0, 1'b0, f);
    idle;

    shoot = 1'b1;
    tick;
    chk("sg_req_before", spawn_req, 1);
    shoot = 1'b0;
    tick;
    startGameEn = 1'b1;
    tick;
    startGameEn = 1'b0;
    exp_shots = 0;
    chk("sg_req", spawn_req, 0);
    chk("sg_shots", shots_fired, 0);
    chk("sg_state", state_dbg, 0);
    idle;

    heat = HEAT_MAX;
    shoot = 1'b1;
    tick;
    chk("oh_state", state_dbg, 3);
    chk("oh_flag", overheat, 1);
    heat = 4'd10;
    tick;
    chk("oh_hold10", overheat, 1);
    chk("oh_noreq10", spawn_req, 0);
    heat = 4'd5;
    tick;
    chk("oh_hold5", overheat, 1);
    chk("oh_noreq5", spawn_req, 0);
    heat = 4'd4;
    shoot = 1'b0;
    tick;
    chk("oh_release", overheat, 0);
    chk("oh_release_state", state_dbg, 0);
    idle;

    trigger(0, 0, 1'b1, 1'b0, f);
    cool;
    idle;

`ifdef GUN_BURST_EN
    trigger(0, 2, 1'b0, 1'b1, f);
    repeat (3) begin
      tick;
      chk("burst_no_retrigger", state_dbg, 0);
    end
    shoot = 1'b0;
    tick;
`endif

    for (int t = 0; t < 30; t++) begin
      idle;
      trigger(0, 10, ($urandom_range(0, 4) == 0), 1'b0, f);
      if (f == 2'd3) cool;
    end

`ifndef GUN_BURST_EN
    heat = 4'd2;
    shoot = 1'b1;
    spawn_ack = 1'b1;
    rises = 0;
    bad = 0;
    last = -1;
    cyc = 0;
    prev = spawn_req;
    while (rises < 260 && cyc < 3000) begin
      tick;
      cyc++;
      if (spawn_req && !prev) begin
        if (last >= 0 && cyc - last != FIRE_DIV + 2) bad++;
        last = cyc;
        rises++;
      end
      prev = spawn_req;
    end
    shoot = 1'b0;
    cyc = 0;
    while (state_dbg != 2'd0 && cyc < 20) begin
      tick;
      cyc++;
    end
    spawn_ack = 1'b0;
    exp_shots = 255;
    chk("auto_rises", rises, 260);
    chk("auto_spacing_bad", bad, 0);
    chk("auto_saturate", shots_fired, exp_shots);
    chk("auto_end_state", state_dbg, 0);
    idle;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
